// File: rtl/pe_loader_ctrl.sv
// ---------------------------------------------------------------------------
// pe_loader_ctrl
//
// Host-side sequencer for a single processing element (PE). One job runs as
// follows:
//   1. Buffer a weight tile (KERNEL_SIZE**2 words) and then an activation
//      tile (ACT_SIZE**2 words) from the upstream stream.
//   2. Burst the weight tile into the PE, then wait for its load-done edge.
//   3. Burst the activation tile into the PE, then wait for its load-done edge.
//   4. Run NUM_OUTPUTS rounds of: start pulse, wait for the compute-done
//      edge, present the result downstream and wait until it is accepted.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   go                  1-cycle job request, ignored while busy
//   in_data/valid/ready upstream tile stream (weights first, then activations)
//   out_data/idx/valid/ready  downstream result stream, tagged with index
//   busy, job_done      job status; job_done is a 1-cycle pulse
//   pe_filt_in, pe_act_in     data words driven to the PE
//   pe_load_en_wght/act, pe_start  single-cycle requests to the PE
//   pe_out, pe_compute_done, pe_load_done_wght/iact  PE responses (levels)
//   dbg_state           current FSM state, for observation only
//
// Handshake rule (both streams): a word moves on a rising clk edge where
// valid and ready are both 1. A producer holds valid and its data stable
// until that edge, and the data does not change while valid is high.
// ---------------------------------------------------------------------------
module pe_loader_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int ACT_SIZE    = 5,
  parameter int NUM_OUTPUTS = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  job_done,
  output logic [DATA_WIDTH-1:0] pe_filt_in,
  output logic [DATA_WIDTH-1:0] pe_act_in,
  output logic                  pe_load_en_wght,
  output logic                  pe_load_en_act,
  output logic                  pe_start,
  input  logic [DATA_WIDTH-1:0] pe_out,
  input  logic                  pe_compute_done,
  input  logic                  pe_load_done_wght,
  input  logic                  pe_load_done_iact,
  output logic [3:0]            dbg_state
);

  localparam int W_WORDS   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int A_WORDS   = ACT_SIZE * ACT_SIZE;
  localparam int MAX_WORDS = (A_WORDS > W_WORDS) ? A_WORDS : W_WORDS;
  localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int W_IDX_W   = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;
  localparam int A_IDX_W   = (A_WORDS > 1) ? $clog2(A_WORDS) : 1;

  localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(W_WORDS - 1);
  localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(A_WORDS - 1);
  localparam logic [7:0]       OUT_LAST = 8'(NUM_OUTPUTS - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FILL_W = 4'd1;
  localparam logic [3:0] S_FILL_A = 4'd2;
  localparam logic [3:0] S_SEND_W = 4'd3;
  localparam logic [3:0] S_WAIT_W = 4'd4;
  localparam logic [3:0] S_SEND_A = 4'd5;
  localparam logic [3:0] S_WAIT_A = 4'd6;
  localparam logic [3:0] S_ISSUE  = 4'd7;
  localparam logic [3:0] S_WAIT_C = 4'd8;
  localparam logic [3:0] S_DRAIN  = 4'd9;

  logic [3:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            out_cnt_q, out_cnt_d;
  logic                  busy_q, busy_d;
  logic                  job_done_q, job_done_d;
  logic                  pe_start_q, pe_start_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]            out_idx_q, out_idx_d;
  logic                  ldw_prev_q, ldw_prev_d;
  logic                  lda_prev_q, lda_prev_d;
  logic                  cd_prev_q, cd_prev_d;

  logic [DATA_WIDTH-1:0] wbuf_q [W_WORDS];
  logic [DATA_WIDTH-1:0] abuf_q [A_WORDS];
  logic                  wbuf_we, abuf_we;

  // The PE holds its done flags high until it idles, so only a 0->1
  // transition means "this request has finished".
  logic ldw_rise, lda_rise, cd_rise;
  assign ldw_rise = pe_load_done_wght & ~ldw_prev_q;
  assign lda_rise = pe_load_done_iact & ~lda_prev_q;
  assign cd_rise  = pe_compute_done   & ~cd_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_cnt_d   = out_cnt_q;
    busy_d      = busy_q;
    job_done_d  = 1'b0;
    pe_start_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    ldw_prev_d  = pe_load_done_wght;
    lda_prev_d  = pe_load_done_iact;
    cd_prev_d   = pe_compute_done;
    wbuf_we     = 1'b0;
    abuf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          busy_d    = 1'b1;
          cnt_d     = '0;
          out_cnt_d = '0;
          state_d   = S_FILL_W;
        end
      end
      S_FILL_W: begin
        if (in_valid) begin
          wbuf_we = 1'b1;
          if (cnt_q == W_LAST) begin
            cnt_d   = '0;
            state_d = S_FILL_A;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FILL_A: begin
        if (in_valid) begin
          abuf_we = 1'b1;
          if (cnt_q == A_LAST) begin
            cnt_d   = '0;
            state_d = S_SEND_W;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // Bursts run on consecutive cycles; the PE does not tolerate gaps.
      S_SEND_W: begin
        if (cnt_q == W_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_W;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_W: begin
        if (ldw_rise) state_d = S_SEND_A;
      end
      S_SEND_A: begin
        if (cnt_q == A_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_A: begin
        if (lda_rise) state_d = S_ISSUE;
      end
      // A stale compute_done from the previous round must clear first,
      // otherwise its level would hide the rising edge of this round.
      S_ISSUE: begin
        if (!pe_compute_done) begin
          pe_start_d = 1'b1;
          state_d    = S_WAIT_C;
        end
      end
      S_WAIT_C: begin
        if (cd_rise) begin
          out_data_d  = pe_out;
          out_idx_d   = out_cnt_q;
          out_valid_d = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d  = '0;
            job_done_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 8'd1;
            state_d   = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_cnt_q   <= '0;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
      pe_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      ldw_prev_q  <= 1'b0;
      lda_prev_q  <= 1'b0;
      cd_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_cnt_q   <= out_cnt_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
      pe_start_q  <= pe_start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      ldw_prev_q  <= ldw_prev_d;
      lda_prev_q  <= lda_prev_d;
      cd_prev_q   <= cd_prev_d;
    end
  end

  // Tile storage carries no reset: its contents are always rewritten
  // before they are read.
  always_ff @(posedge clk) begin
    if (wbuf_we) wbuf_q[cnt_q[W_IDX_W-1:0]] <= in_data;
    if (abuf_we) abuf_q[cnt_q[A_IDX_W-1:0]] <= in_data;
  end

  // Load enables are decoded from the first burst cycle only, so they are
  // single-cycle by construction; data is forced to 0 outside the bursts.
  assign in_ready        = (state_q == S_FILL_W) || (state_q == S_FILL_A);
  assign pe_load_en_wght = (state_q == S_SEND_W) && (cnt_q == '0);
  assign pe_load_en_act  = (state_q == S_SEND_A) && (cnt_q == '0);
  assign pe_filt_in      = (state_q == S_SEND_W) ? wbuf_q[cnt_q[W_IDX_W-1:0]] : '0;
  assign pe_act_in       = (state_q == S_SEND_A) ? abuf_q[cnt_q[A_IDX_W-1:0]] : '0;
  assign pe_start        = pe_start_q;
  assign out_data        = out_data_q;
  assign out_idx         = out_idx_q;
  assign out_valid       = out_valid_q;
  assign busy            = busy_q;
  assign job_done        = job_done_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_pe_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_loader_ctrl
//
// Bench for pe_loader_ctrl. A stub PE answers load and start requests; a
// single negedge process checks every cycle against a tile/output model
// (expected burst words in arrays, expected results in exp_q) and drives
// the PE responses and out_ready. Directed jobs run from the main initial.
// ---------------------------------------------------------------------------
module tb_pe_loader_ctrl;
  localparam int DW = 16;
  localparam int K  = 3;
  localparam int A  = 5;
  localparam int NO = 9;
  localparam int WN = K * K;
  localparam int AN = A * A;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_idx;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy, job_done;
  logic [DW-1:0] pe_filt_in, pe_act_in;
  logic          pe_load_en_wght, pe_load_en_act, pe_start;
  logic [DW-1:0] pe_out = '0;
  logic          pe_compute_done = 1'b0;
  logic          pe_load_done_wght = 1'b0;
  logic          pe_load_done_iact = 1'b0;
  logic [3:0]    dbg_state;

  pe_loader_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .ACT_SIZE(A), .NUM_OUTPUTS(NO)) dut (
    .clk(clk), .reset(reset), .go(go),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .job_done(job_done),
    .pe_filt_in(pe_filt_in), .pe_act_in(pe_act_in),
    .pe_load_en_wght(pe_load_en_wght), .pe_load_en_act(pe_load_en_act), .pe_start(pe_start),
    .pe_out(pe_out), .pe_compute_done(pe_compute_done),
    .pe_load_done_wght(pe_load_done_wght), .pe_load_done_iact(pe_load_done_iact),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- model state ----------------
  logic [DW-1:0] exp_w [WN];
  logic [DW-1:0] exp_a [AN];
  logic [23:0]   exp_q [$];   // {idx, data} of each expected result
  logic [23:0]   e;
  int w_pos = 0, a_pos = 0;
  bit w_done_seen = 0;
  int cyc = 0, last_hs_cyc = 0;
  int ir_cycles = 0, hs_cnt = 0, out_cnt = 0, jd_cnt = 0;
  int first_filt = 0, last_filt = 0, first_act = 0, last_act = 0, last_data = 0;
  int stall_idx = -1, stall_len = 0, stall_cnt = 0;
  bit prev_hold = 0;
  logic [DW-1:0] prev_data = '0;
  logic [7:0]    prev_idx = '0;

  // stub PE state
  int hold_c = 1;
  int w_tmr = 0, a_tmr = 0, c_tmr = 0, w_hold = 0, a_hold = 0, c_hold = 0, start_n = 0;

  // ---------------- compare process + stub PE ----------------
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      w_pos = 0; a_pos = 0; w_done_seen = 0;
      exp_q.delete();
      prev_hold = 0;
      out_ready = 1'b1;
      pe_load_done_wght = 1'b0; pe_load_done_iact = 1'b0; pe_compute_done = 1'b0;
      pe_out = '0;
      w_tmr = 0; a_tmr = 0; c_tmr = 0; w_hold = 0; a_hold = 0; c_hold = 0; start_n = 0;
    end else begin
      // downstream: optional stall on one index
      if (out_valid && stall_idx >= 0 && out_idx == stall_idx[7:0] && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_idx", out_idx, prev_idx);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_output: idx %0d data %0d, none expected", out_idx, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_idx", out_idx, e[23:16]);
          chk("out_data", out_data, e[15:0]);
          out_cnt++;
          last_data = out_data;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_idx  = out_idx;

      // upstream
      if (in_ready) ir_cycles++;
      if (in_valid && in_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
      end

      // weight burst: en on word 0 only, words on consecutive cycles
      if (pe_load_en_wght) begin
        chk("wght_en_mid_burst", w_pos, 0);
        chk("go_to_wload_latency", cyc - last_hs_cyc, 1);
        chk("filt_word", pe_filt_in, exp_w[0]);
        first_filt = pe_filt_in;
        w_pos = 1;
        w_done_seen = 0;
      end else if (w_pos > 0) begin
        chk("filt_word", pe_filt_in, exp_w[w_pos]);
        if (w_pos == WN - 1) last_filt = pe_filt_in;
        w_pos++;
        if (w_pos == WN) w_pos = 0;
      end else begin
        chk("filt_idle_zero", pe_filt_in, 0);
      end

      // activation burst, only after the weight load completed
      if (pe_load_en_act) begin
        chk("act_en_mid_burst", a_pos, 0);
        chk("act_after_wdone", w_done_seen, 1);
        chk("act_word", pe_act_in, exp_a[0]);
        first_act = pe_act_in;
        a_pos = 1;
      end else if (a_pos > 0) begin
        chk("act_word", pe_act_in, exp_a[a_pos]);
        if (a_pos == AN - 1) last_act = pe_act_in;
        a_pos++;
        if (a_pos == AN) a_pos = 0;
      end else begin
        chk("act_idle_zero", pe_act_in, 0);
      end

      if (pe_start) begin
        chk("start_with_load", {pe_load_en_wght, pe_load_en_act}, 0);
        chk("start_done_low", pe_compute_done, 0);
        chk("start_out_idle", out_valid, 0);
      end

      if (job_done) begin
        jd_cnt++;
        chk("busy_at_job_done", busy, 0);
        chk("outputs_left", exp_q.size(), 0);
      end

      // stub PE reacts to this cycle's requests
      if (pe_load_en_wght) begin
        pe_load_done_wght = 1'b0; w_tmr = WN + 2; start_n = 0;
      end else if (w_tmr > 0) begin
        w_tmr--;
        if (w_tmr == 0) begin pe_load_done_wght = 1'b1; w_done_seen = 1; w_hold = 3; end
      end else if (w_hold > 0) begin
        w_hold--;
        if (w_hold == 0) pe_load_done_wght = 1'b0;
      end

      if (pe_load_en_act) begin
        pe_load_done_iact = 1'b0; a_tmr = AN + 2;
      end else if (a_tmr > 0) begin
        a_tmr--;
        if (a_tmr == 0) begin pe_load_done_iact = 1'b1; a_hold = 3; end
      end else if (a_hold > 0) begin
        a_hold--;
        if (a_hold == 0) pe_load_done_iact = 1'b0;
      end

      if (pe_start) begin
        c_tmr = 5;
      end else if (c_tmr > 0) begin
        c_tmr--;
        if (c_tmr == 0) begin
          pe_out = DW'(200 + start_n);
          start_n++;
          pe_compute_done = 1'b1;
          c_hold = hold_c;
        end
      end else if (c_hold > 0) begin
        c_hold--;
        if (c_hold == 0) pe_compute_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_busy_jd", {busy, job_done}, 0);
    chk("rst_pe_req", {pe_load_en_wght, pe_load_en_act, pe_start}, 0);
    chk("rst_pe_data", {pe_filt_in, pe_act_in}, 0);
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w, input int gap);
    bit ok;
    ok = 0;
    in_data  = w;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL in_ready_wait: word %0d never accepted", w);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    if (gap != 0) begin @(posedge clk); #1; end
  endtask

  task automatic load_tiles(input int gap, input int wbase, input int abase);
    for (int i = 0; i < WN; i++) exp_w[i] = DW'(wbase + i);
    for (int i = 0; i < AN; i++) exp_a[i] = DW'(abase + i);
    pulse_go();
    chk("busy_after_go", busy, 1);
    for (int i = 0; i < WN; i++) push_word(exp_w[i], gap);
    for (int i = 0; i < AN; i++) push_word(exp_a[i], gap);
  endtask

  task automatic run_job(input int gap, input int wbase, input int abase, input int go_at);
    int jd0;
    bit gone;
    gone = 0;
    ir_cycles = 0; hs_cnt = 0; out_cnt = 0; jd0 = jd_cnt;
    for (int n = 0; n < NO; n++) exp_q.push_back({8'(n), DW'(200 + n)});
    load_tiles(gap, wbase, abase);
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk); #1;
      if (jd_cnt != jd0) break;
      if (go_at >= 0 && !gone && out_cnt == go_at) begin
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        chk("busy_ignores_go", busy, 1);
        gone = 1;
      end
    end
    chk("job_done_pulses", jd_cnt - jd0, 1);
    chk("outputs_per_job", out_cnt, NO);
    chk("handshakes_per_job", hs_cnt, WN + AN);
    @(negedge clk); #1;
    chk("busy_after_job", busy, 0);
    chk("single_job_done", job_done, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #3 check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // burst timing and full job, out_ready always high
    run_job(0, 1, 101, -1);
    chk("t1_in_ready_cycles", ir_cycles, 34);
    chk("t1_first_filt", first_filt, 1);
    chk("t1_last_filt", last_filt, 9);
    chk("t1_first_act", first_act, 101);
    chk("t1_last_act", last_act, 125);
    chk("t1_last_out", last_data, 208);

    // compute_done held 3 extra cycles
    hold_c = 4;
    run_job(0, 11, 301, -1);
    hold_c = 1;
    chk("t2_last_out", last_data, 208);

    // downstream stall on output 3
    stall_idx = 3; stall_len = 10; stall_cnt = 0;
    run_job(0, 21, 401, -1);
    chk("t3_stall_cycles", stall_cnt, 10);
    stall_idx = -1;

    // upstream gaps, same tiles as the first job
    run_job(1, 1, 101, -1);
    chk("t4_first_filt", first_filt, 1);
    chk("t4_last_act", last_act, 125);

    // reset in the middle of the activation burst
    load_tiles(0, 1, 101);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (a_pos == 11) break;
    end
    chk("t5_reached_act_word10", pe_act_in, 111);
    #1 reset = 1'b1;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // fresh job after reset, with a go issued mid-job
    run_job(0, 1, 101, 4);
    chk("t6_last_out", last_data, 208);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // hard stop in case something above never returns
  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_loader_ctrl.md
Name: pe_loader_ctrl

Overview:
Host-side sequencer for one PE. It buffers a weight tile and an activation tile from an upstream valid/ready stream, then bursts each tile into the PE over the PE load protocol. It then issues one start pulse per output and returns each PE result to a downstream valid/ready stream tagged with its index. It drives the PE's load_en_wght/load_en_act/start inputs and consumes its load_done_wght/load_done_iact/compute_done/pe_out outputs.

Parameters:
DATA_WIDTH, 16, word width of the stream and PE data.
KERNEL_SIZE, 3, kernel edge; a weight tile is KERNEL_SIZE**2 words.
ACT_SIZE, 5, activation edge; an activation tile is ACT_SIZE**2 words.
NUM_OUTPUTS, 9, start/compute_done transactions per job.

Ports:
clk  input  1  clock, all logic on posedge.
reset  input  1  asynchronous active-high reset.
go  input  1  1-cycle job request; ignored while busy=1.
in_data  input  DATA_WIDTH  tile word; all weights first, then all activations, row-major.
in_valid  input  1  in_data valid.
in_ready  output  1  word accepted when in_valid&in_ready.
out_data  output  DATA_WIDTH  captured pe_out.
out_idx  output  8  output index 0..NUM_OUTPUTS-1.
out_valid  output  1  out_data/out_idx valid; held until out_ready.
out_ready  input  1  downstream accept.
busy  output  1  high from go accept until job_done.
job_done  output  1  1-cycle pulse after the last output is accepted.
pe_filt_in  output  DATA_WIDTH  weight word to PE.
pe_act_in  output  DATA_WIDTH  activation word to PE.
pe_load_en_wght  output  1  weight-load request to PE.
pe_load_en_act  output  1  activation-load request to PE.
pe_start  output  1  compute request to PE.
pe_out  input  DATA_WIDTH  PE result.
pe_compute_done  input  1  PE compute complete (level).
pe_load_done_wght  input  1  PE weight load complete (level).
pe_load_done_iact  input  1  PE activation load complete (level).

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0, including in_ready, out_valid, pe_* requests and data; counters and edge-detect registers 0. The buffer contents are don't-care.
- Storage: WBUF of KERNEL_SIZE**2 words, ABUF of ACT_SIZE**2 words, one word counter, one output counter.
- States:
  - IDLE: on go, set busy=1 and go to FILL_W.
  - FILL_W: in_ready=1; each handshake writes WBUF[cnt] and increments cnt. After word KERNEL_SIZE**2-1, go to FILL_A with cnt=0.
  - FILL_A: same as FILL_W for ABUF and ACT_SIZE**2 words; then go to SEND_W with in_ready=0.
  - SEND_W: cycle 0 drives pe_load_en_wght=1 and pe_filt_in=WBUF[0]. Cycles 1..K²-1 drive pe_load_en_wght=0 and pe_filt_in=WBUF[i]. Words go out on consecutive cycles with no gaps. Then go to WAIT_W with pe_filt_in=0.
  - WAIT_W: wait for a rising edge of pe_load_done_wght, then go to SEND_A.
  - SEND_A / WAIT_A: identical to SEND_W / WAIT_W, using pe_load_en_act, pe_act_in, ABUF and pe_load_done_iact.
  - ISSUE: wait until pe_compute_done==0, then drive pe_start=1 for exactly one cycle and go to WAIT_C.
  - WAIT_C: on a rising edge of pe_compute_done, capture pe_out into out_data, set out_idx to the output counter, set out_valid=1, and go to DRAIN.
  - DRAIN: when out_valid&out_ready, clear out_valid and increment the output counter. If the counter was NUM_OUTPUTS-1, pulse job_done, clear busy and go to IDLE. Otherwise go to ISSUE.
- Load and start requests are always single-cycle pulses. A level-held request would restart the PE when it re-enters IDLE.
- Completion is detected only by a rising edge of the PE done signal, never by its level. The PE holds done flags high until it idles with no request.
- pe_start is never asserted in the same cycle as either load enable.
- Weights are always re-sent before activations on every job. The PE relies on its weight load to reset its internal word counter.
- A go during busy is ignored. in_valid outside FILL_W/FILL_A is ignored, because in_ready=0 there.
- A downstream stall (out_ready=0) blocks the next pe_start indefinitely. out_data and out_idx stay stable while out_valid=1.
- If out_ready is already high when out_valid rises, the handshake completes in that cycle.
- Latency from go to first pe_load_en_wght: (K² + A²) handshakes + 1 cycle.

Test Plan:
- Load burst timing: go, then 9 weights (1..9) and 25 activations (101..125) with in_valid always high. Required: in_ready high for exactly 34 cycles; pe_load_en_wght high for 1 cycle; pe_filt_in shows 1..9 on 9 consecutive cycles; pe_act_in shows 101..125 on 25 consecutive cycles after the load_done_wght edge.
- Full job with a stub PE (done 5 cycles after start, level held until start is low for 1 cycle; pe_out=200+n) and out_ready=1. Required: 9 outputs with out_idx 0..8 and out_data 200..208; exactly one job_done pulse; busy low afterwards.
- Stale done: stub PE holds compute_done high for 3 extra cycles. Required: the next pe_start does not occur until compute_done is sampled low, and no duplicate output is produced.
- Backpressure: out_ready low for 10 cycles on output 3. Required: out_data=203 and out_idx=3 stable throughout; no pe_start during the stall; job still ends with 9 outputs.
- Upstream gaps: in_valid toggling 1/0. Required: buffers are filled correctly and the PE burst is still gap-free, with the same pe_filt_in and pe_act_in sequences as the first test.
- Reset mid-SEND_A: assert reset at activation word 10. Required: all outputs go to 0 immediately. A fresh go afterwards reruns the full sequence correctly; go while busy is ignored.
